// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle vertical-motion engine.
// Define DOODLE_TERMINAL_VEL_EN to cap fall speed at MAX_FALL_V.
package doodle_pkg;

    typedef logic [9:0] ypos_t;
    typedef logic [5:0] vel_t;

    typedef enum logic [2:0] {
        StIdle,
        StRise,
        StFall,
        StBounce,
        StScroll
    } jump_state_t;

    localparam ypos_t DOODLE_H    = 10'd80;
    localparam ypos_t EARTH       = 10'd700;
    localparam ypos_t REST_Y      = EARTH - DOODLE_H;
    localparam ypos_t SCROLL_LINE = 10'd420;
    localparam vel_t  JUMP_V0     = 6'd20;
    localparam vel_t  MAX_FALL_V  = 6'd12;

`ifdef DOODLE_TERMINAL_VEL_EN
    localparam vel_t FALL_V_CAP = MAX_FALL_V;
`else
    localparam vel_t FALL_V_CAP = 6'd63;
`endif

    // Widen to 11 bits so a downward move clips at the bottom instead of wrapping.
    function automatic ypos_t sat_add(input ypos_t a, input ypos_t b);
        logic [10:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[10] ? 10'h3ff : sum[9:0];
    endfunction

endpackage

// File: rtl/doodle_kinematics_step.sv
// One frame of gravity: next y and velocity for RISE/FALL, saturating both ends.
module doodle_kinematics_step
    import doodle_pkg::*;
(
    input  jump_state_t state,
    input  ypos_t       y,
    input  vel_t        vel,
    input  vel_t        vel_max,
    output ypos_t       y_next,
    output vel_t        vel_next
);

    vel_t vel_inc;

    always_comb begin
        y_next   = y;
        vel_next = vel;
        vel_inc  = vel;
        if (state == StRise) begin
            y_next   = (y > {4'd0, vel}) ? y - {4'd0, vel} : '0;
            vel_next = vel - 6'd1;
        end else if (state == StFall) begin
            vel_inc  = (vel >= vel_max) ? vel_max : vel + 6'd1;
            vel_next = vel_inc;
            y_next   = sat_add(y, {4'd0, vel_inc});
        end
    end

endmodule

// File: rtl/doodle_jump_controller.sv
// Doodle vertical-motion FSM: gravity per frame, landing snap/bounce, scroll handshake.
// Optional build macro DOODLE_TERMINAL_VEL_EN caps fall velocity (see doodle_pkg).
module doodle_jump_controller
    import doodle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       doodle_collision,
    input  logic       move_collision,
    input  logic [9:0] ground_y,
    output logic [9:0] doodle_y,
    output logic       doodle_fall_direction,
    output logic [5:0] velocity,
    output logic       scroll_valid,
    input  logic       scroll_ready,
    output logic [9:0] scroll_dy
);

    jump_state_t state_q, state_d;
    ypos_t       y_q, y_d, ground_q, ground_d, dy_q, dy_d;
    vel_t        vel_q, vel_d;
    logic        fall_q, fall_d, sv_q, sv_d, move_q, move_d;
    ypos_t       step_y;
    vel_t        step_vel;

    doodle_kinematics_step u_step (
        .state    (state_q),
        .y        (y_q),
        .vel      (vel_q),
        .vel_max  (FALL_V_CAP),
        .y_next   (step_y),
        .vel_next (step_vel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            y_q      <= REST_Y;
            vel_q    <= '0;
            fall_q   <= 1'b0;
            sv_q     <= 1'b0;
            dy_q     <= '0;
            move_q   <= 1'b0;
            ground_q <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            fall_q   <= fall_d;
            sv_q     <= sv_d;
            dy_q     <= dy_d;
            move_q   <= move_d;
            ground_q <= ground_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        vel_d    = vel_q;
        fall_d   = fall_q;
        sv_d     = sv_q;
        dy_d     = dy_q;
        move_d   = move_q;
        ground_d = ground_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRise;
                    vel_d   = JUMP_V0;
                end
            end
            StRise: begin
                if (frame_tick) begin
                    y_d   = step_y;
                    vel_d = step_vel;
                    if (step_vel == '0) begin
                        state_d = StFall;
                        fall_d  = 1'b1;
                    end
                end
            end
            StFall: begin
                if (frame_tick) begin
                    if (doodle_collision) begin
                        // Snap onto the surface; velocity is kept until the bounce.
                        y_d      = (ground_y < DOODLE_H) ? '0 : ground_y - DOODLE_H;
                        move_d   = move_collision;
                        ground_d = ground_y;
                        state_d  = StBounce;
                    end else begin
                        y_d   = step_y;
                        vel_d = step_vel;
                    end
                end
            end
            StBounce: begin
                if (move_q) begin
                    sv_d    = 1'b1;
                    dy_d    = (ground_q >= SCROLL_LINE) ? '0 : SCROLL_LINE - ground_q;
                    state_d = StScroll;
                end else begin
                    state_d = StRise;
                    vel_d   = JUMP_V0;
                    fall_d  = 1'b0;
                end
            end
            StScroll: begin
                if (sv_q && scroll_ready) begin
                    y_d     = sat_add(y_q, dy_q);
                    sv_d    = 1'b0;
                    state_d = StRise;
                    vel_d   = JUMP_V0;
                    fall_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign doodle_y              = y_q;
    assign doodle_fall_direction = fall_q;
    assign velocity              = vel_q;
    assign scroll_valid          = sv_q;
    assign scroll_dy             = dy_q;

endmodule

// File: tb/tb_doodle_jump_controller.sv
// Self-checking bench: directed scenarios plus randomized run against a behavioural model.
module tb_doodle_jump_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       doodle_collision = 1'b0;
    logic       move_collision = 1'b0;
    logic [9:0] ground_y = '0;
    logic [9:0] doodle_y;
    logic       doodle_fall_direction;
    logic [5:0] velocity;
    logic       scroll_valid;
    logic       scroll_ready = 1'b0;
    logic [9:0] scroll_dy;

    int checks = 0;
    int errors = 0;

`ifdef DOODLE_TERMINAL_VEL_EN
    localparam int CAP = 12;
`else
    localparam int CAP = 63;
`endif

    localparam int M_IDLE = 0, M_RISE = 1, M_FALL = 2, M_LANDED = 3, M_WAIT = 4;

    int m_mode = M_IDLE, m_y = 620, m_v = 0, m_dy = 0, m_lg = 0;
    bit m_fall = 0, m_sv = 0, m_lm = 0;

    doodle_jump_controller dut (
        .clk                   (clk),
        .rst                   (rst),
        .frame_tick            (frame_tick),
        .start                 (start),
        .doodle_collision      (doodle_collision),
        .move_collision        (move_collision),
        .ground_y              (ground_y),
        .doodle_y              (doodle_y),
        .doodle_fall_direction (doodle_fall_direction),
        .velocity              (velocity),
        .scroll_valid          (scroll_valid),
        .scroll_ready          (scroll_ready),
        .scroll_dy             (scroll_dy)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit st, input bit ft, input bit dc,
                              input bit mc, input int gy, input bit rdy);
        if (r) begin
            m_mode = M_IDLE; m_y = 620; m_v = 0; m_fall = 0; m_sv = 0; m_dy = 0;
            m_lm = 0; m_lg = 0;
            return;
        end
        case (m_mode)
            M_IDLE: if (st) begin m_mode = M_RISE; m_v = 20; end
            M_RISE: if (ft) begin
                m_y = (m_y > m_v) ? m_y - m_v : 0;
                m_v = m_v - 1;
                if (m_v == 0) begin m_mode = M_FALL; m_fall = 1; end
            end
            M_FALL: if (ft) begin
                if (dc) begin
                    m_y = (gy < 80) ? 0 : gy - 80;
                    m_lm = mc; m_lg = gy; m_mode = M_LANDED;
                end else begin
                    m_v = (m_v + 1 > CAP) ? CAP : m_v + 1;
                    m_y = (m_y + m_v > 1023) ? 1023 : m_y + m_v;
                end
            end
            M_LANDED: if (m_lm) begin
                m_sv = 1; m_dy = (m_lg >= 420) ? 0 : 420 - m_lg; m_mode = M_WAIT;
            end else begin
                m_mode = M_RISE; m_v = 20; m_fall = 0;
            end
            M_WAIT: if (m_sv && rdy) begin
                m_y = (m_y + m_dy > 1023) ? 1023 : m_y + m_dy;
                m_sv = 0; m_mode = M_RISE; m_v = 20; m_fall = 0;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic step(input bit r, input bit st, input bit ft, input bit dc,
                        input bit mc, input int gy, input bit rdy);
        @(negedge clk);
        rst = r; start = st; frame_tick = ft; doodle_collision = dc;
        move_collision = mc; ground_y = 10'(gy); scroll_ready = rdy;
        @(posedge clk);
        model_step(r, st, ft, dc, mc, gy, rdy);
        #1;
    endtask

    // Frame tick followed by a quiet clk, honouring the minimum tick spacing.
    task automatic frame(input bit dc, input bit mc, input int gy);
        step(0, 0, 1, dc, mc, gy, 0);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (doodle_y !== 10'd620) begin errors++; $display("FAIL reset_y got %0d want 620", doodle_y); end
        checks++; if (velocity !== 6'd0) begin errors++; $display("FAIL reset_vel got %0d want 0", velocity); end
        checks++; if (doodle_fall_direction !== 1'b0) begin errors++; $display("FAIL reset_fall got %0d want 0", doodle_fall_direction); end
        checks++; if (scroll_valid !== 1'b0 || scroll_dy !== 10'd0) begin errors++; $display("FAIL reset_scroll got %0d/%0d want 0/0", scroll_valid, scroll_dy); end
        step(0, 0, 1, 0, 0, 0, 0);
        checks++; if (velocity !== 6'd0) begin errors++; $display("FAIL idle_tick_vel got %0d want 0", velocity); end
    endtask

    task automatic test_rise;
        int exp_y;
        step(0, 1, 0, 0, 0, 0, 0);
        checks++; if (velocity !== 6'd20) begin errors++; $display("FAIL start_vel got %0d want 20", velocity); end
        exp_y = 620;
        for (int i = 0; i < 20; i++) begin
            exp_y -= 20 - i;
            frame(1, 0, 300);  // collisions during RISE must be ignored
            checks++; if (doodle_y !== 10'(exp_y)) begin errors++; $display("FAIL rise_y[%0d] got %0d want %0d", i, doodle_y, exp_y); end
        end
        checks++; if (doodle_y !== 10'd410 || velocity !== 6'd0 || doodle_fall_direction !== 1'b1) begin
            errors++; $display("FAIL rise_top got y%0d v%0d f%0d want y410 v0 f1", doodle_y, velocity, doodle_fall_direction);
        end
    endtask

    task automatic test_fall;
        int exp_y, exp_v;
        for (int i = 0; i < 20; i++) frame(0, 0, 0);
        exp_v = (CAP == 63) ? 20 : 12;
        exp_y = (CAP == 63) ? 620 : 584;
        checks++; if (doodle_y !== 10'(exp_y)) begin errors++; $display("FAIL fall_y got %0d want %0d", doodle_y, exp_y); end
        checks++; if (velocity !== 6'(exp_v)) begin errors++; $display("FAIL fall_vel got %0d want %0d", velocity, exp_v); end
    endtask

    task automatic test_bounce;
        step(0, 0, 1, 1, 0, 500, 0);
        checks++; if (doodle_y !== 10'd420 || doodle_fall_direction !== 1'b1) begin
            errors++; $display("FAIL land_y got y%0d f%0d want y420 f1", doodle_y, doodle_fall_direction);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++; if (velocity !== 6'd20 || doodle_fall_direction !== 1'b0 || scroll_valid !== 1'b0) begin
            errors++; $display("FAIL bounce got v%0d f%0d s%0d want v20 f0 s0", velocity, doodle_fall_direction, scroll_valid);
        end
    endtask

    task automatic test_scroll;
        for (int i = 0; i < 20; i++) frame(1, 1, 100);
        checks++; if (doodle_y !== 10'd210 || doodle_fall_direction !== 1'b1) begin
            errors++; $display("FAIL rise2_top got y%0d f%0d want y210 f1", doodle_y, doodle_fall_direction);
        end
        step(0, 0, 1, 1, 1, 400, 0);
        checks++; if (doodle_y !== 10'd320) begin errors++; $display("FAIL scroll_land got %0d want 320", doodle_y); end
        step(0, 0, 0, 0, 0, 0, 1);  // early ready is harmless
        checks++; if (scroll_valid !== 1'b1 || scroll_dy !== 10'd20) begin
            errors++; $display("FAIL scroll_req got v%0d dy%0d want v1 dy20", scroll_valid, scroll_dy);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 1, (i % 2 == 0), 1, 0, 600, 0);
            checks++; if (scroll_valid !== 1'b1 || scroll_dy !== 10'd20 || doodle_y !== 10'd320) begin
                errors++; $display("FAIL scroll_hold[%0d] got v%0d dy%0d y%0d want v1 dy20 y320", i, scroll_valid, scroll_dy, doodle_y);
            end
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++; if (doodle_y !== 10'd340 || scroll_valid !== 1'b0 || velocity !== 6'd20 || doodle_fall_direction !== 1'b0) begin
            errors++; $display("FAIL scroll_done got y%0d s%0d v%0d f%0d want y340 s0 v20 f0", doodle_y, scroll_valid, velocity, doodle_fall_direction);
        end
    endtask

    task automatic test_top_saturate;
        for (int i = 0; i < 20; i++) frame(0, 0, 0);
        step(0, 0, 1, 1, 0, 95, 0);
        checks++; if (doodle_y !== 10'd15) begin errors++; $display("FAIL low_land got %0d want 15", doodle_y); end
        step(0, 0, 0, 0, 0, 0, 0);
        frame(0, 0, 0);
        checks++; if (doodle_y !== 10'd0 || velocity !== 6'd19) begin
            errors++; $display("FAIL top_sat got y%0d v%0d want y0 v19", doodle_y, velocity);
        end
        for (int i = 0; i < 19; i++) frame(0, 0, 0);
        step(0, 0, 1, 1, 0, 50, 0);
        checks++; if (doodle_y !== 10'd0) begin errors++; $display("FAIL snap_zero got %0d want 0", doodle_y); end
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_scroll;
        for (int i = 0; i < 20; i++) frame(0, 0, 0);
        step(0, 0, 1, 1, 1, 450, 0);
        checks++; if (doodle_y !== 10'd370) begin errors++; $display("FAIL deep_land got %0d want 370", doodle_y); end
        step(0, 0, 0, 0, 0, 0, 0);
        checks++; if (scroll_valid !== 1'b1 || scroll_dy !== 10'd0) begin
            errors++; $display("FAIL zero_dy got v%0d dy%0d want v1 dy0", scroll_valid, scroll_dy);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        checks++; if (scroll_valid !== 1'b0 || doodle_y !== 10'd620 || velocity !== 6'd0 || doodle_fall_direction !== 1'b0) begin
            errors++; $display("FAIL rst_scroll got s%0d y%0d v%0d f%0d want s0 y620 v0 f0", scroll_valid, doodle_y, velocity, doodle_fall_direction);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        checks++; if (velocity !== 6'd0 || scroll_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst got v%0d s%0d want v0 s0", velocity, scroll_valid);
        end
    endtask

    task automatic test_random;
        int since = 2;
        bit r, st, ft, dc, mc, rdy;
        int gy;
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom % 250) == 0;
            st  = ($urandom % 4) == 0;
            ft  = (since >= 2) && (($urandom % 3) != 0);
            dc  = ($urandom % 5) == 0;
            mc  = $urandom % 2;
            gy  = $urandom_range(0, 1023);
            rdy = ($urandom % 3) == 0;
            since = ft ? 1 : since + 1;
            step(r, st, ft, dc, mc, gy, rdy);
            checks++;
            if (doodle_y !== 10'(m_y) || velocity !== 6'(m_v) || doodle_fall_direction !== m_fall ||
                scroll_valid !== m_sv || scroll_dy !== 10'(m_dy)) begin
                errors++;
                $display("FAIL random[%0d] got y%0d v%0d f%0d s%0d dy%0d want y%0d v%0d f%0d s%0d dy%0d",
                         i, doodle_y, velocity, doodle_fall_direction, scroll_valid, scroll_dy,
                         m_y, m_v, m_fall, m_sv, m_dy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_bounce();
        test_scroll();
        test_top_saturate();
        test_reset_mid_scroll();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
